// File: rtl/gate_fb_pkg.sv
// -----------------------------------------------------------------------------
// gate_fb_pkg
// Shared definitions for the gate feedback monitor:
//   - encoding of the per-channel command/feedback mismatch FSM
//   - default tick and debounce constants
//   - cnt_width(): number of bits needed to hold a value 0..max_val
// Optional feature macro used by the top level: GATE_FB_FAULT_CNT_EN
// -----------------------------------------------------------------------------
package gate_fb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_FAULT = 2'd2
   } mm_state_t;

   localparam int CLK_FREQ_MHZ_DEF = 50;
   localparam int DEB_US_DEF       = 4;
   localparam int MISMATCH_US_DEF  = 20;

   // Smallest width able to represent every value in 0..max_val (at least 1 bit).
   function automatic int cnt_width(input int max_val);
      int w;
      w = 31;
      for (int i = 30; i >= 1; i--) begin
         if ((32'sd1 <<< i) > max_val) begin
            w = i;
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/fb_debounce.sv
// -----------------------------------------------------------------------------
// fb_debounce
// One asynchronous feedback line: 2-FF synchroniser followed by a debouncer that
// samples on the 1 us tick. The debounced value flips after DEB_US consecutive
// tick samples that differ from it.
// INVERT=1 treats the line as active-low: the synchroniser idles high and the
// synchronised level is inverted before debouncing, so dout is active-high.
// Ports:
//   clk   in  system clock
//   rst   in  synchronous reset, active-high
//   tick  in  1-cycle sampling strobe (1 us)
//   din   in  asynchronous input line
//   dout  out debounced, active-high value (registered)
// -----------------------------------------------------------------------------
module fb_debounce
   import gate_fb_pkg::*;
#(
   parameter int DEB_US = DEB_US_DEF,
   parameter bit INVERT = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic din,
   output logic dout
);

   localparam int CW = cnt_width(DEB_US);

   logic          sync1;
   logic          sync2;
   logic          sample;
   logic [CW-1:0] cnt;

   // Two-stage synchroniser; idles at the inactive level of the line.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= INVERT;
         sync2 <= INVERT;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
      end
   end

   assign sample = sync2 ^ INVERT;

   // Count consecutive differing tick samples; flip on the DEB_US-th one.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= {CW{1'b0}};
         dout <= 1'b0;
      end else if (tick) begin
         if (sample == dout) begin
            cnt <= {CW{1'b0}};
         end else if (cnt == CW'(DEB_US - 1)) begin
            dout <= sample;
            cnt  <= {CW{1'b0}};
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/gate_feedback_monitor.sv
// -----------------------------------------------------------------------------
// gate_feedback_monitor
// Receive side of the IGBT/SCR gate drive path. Debounces gate feedback and
// DESAT lines, compares feedback with the commanded state, latches mismatch and
// DESAT faults and raises a registered trip request.
// Optional feature macro: GATE_FB_FAULT_CNT_EN adds fault_cnt, a saturating
// count of fault_any rising edges cleared only by sys_rst.
// Ports:
//   sys_clk, sys_rst       clock, synchronous active-high reset
//   IGBT_cmd, SCR_cmd      commanded on/off state (synchronous)
//   IGBT_fb, SCR_fb        gate / conduction feedback (asynchronous)
//   IGBT_desat_n           DESAT from driver, active-low (asynchronous)
//   fault_clr              1-cycle pulse clearing faults whose cause is gone
//   IGBT_fb_db, SCR_fb_db  debounced feedback
//   IGBT_fault, SCR_fault  latched mismatch faults
//   desat_flag             latched DESAT per IGBT
//   fault_any              OR of all latched fault bits
//   trip_req               fault_any delayed by one clock
//   fault_cnt              (GATE_FB_FAULT_CNT_EN only) fault_any rising edges
// -----------------------------------------------------------------------------
module gate_feedback_monitor
   import gate_fb_pkg::*;
#(
   parameter int CLK_FREQ_MHZ = CLK_FREQ_MHZ_DEF,
   parameter int N_IGBT       = 5,
   parameter int N_SCR        = 2,
   parameter int DEB_US       = DEB_US_DEF,
   parameter int MISMATCH_US  = MISMATCH_US_DEF
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic [N_IGBT-1:0] IGBT_cmd,
   input  logic [N_SCR-1:0]  SCR_cmd,
   input  logic [N_IGBT-1:0] IGBT_fb,
   input  logic [N_IGBT-1:0] IGBT_desat_n,
   input  logic [N_SCR-1:0]  SCR_fb,
   input  logic              fault_clr,
   output logic [N_IGBT-1:0] IGBT_fb_db,
   output logic [N_SCR-1:0]  SCR_fb_db,
   output logic [N_IGBT-1:0] IGBT_fault,
   output logic [N_SCR-1:0]  SCR_fault,
   output logic [N_IGBT-1:0] desat_flag,
   output logic              fault_any,
   output logic              trip_req
`ifdef GATE_FB_FAULT_CNT_EN
   ,
   output logic [7:0]        fault_cnt
`endif
);

   localparam int NCH = N_IGBT + N_SCR;
   localparam int PW  = cnt_width(CLK_FREQ_MHZ - 1);
   localparam int TW  = cnt_width(MISMATCH_US);

   logic [PW-1:0]     presc;
   logic              tick;
   logic [N_IGBT-1:0] desat_db;
   logic [NCH-1:0]    cmd_all;
   logic [NCH-1:0]    fb_all;
   logic [NCH-1:0]    eq;
   logic [NCH-1:0]    fault_vec;
   mm_state_t         state     [NCH];
   mm_state_t         state_nxt [NCH];
   logic [TW-1:0]     timer     [NCH];
   logic [TW-1:0]     timer_nxt [NCH];

   assign tick = (presc == PW'(CLK_FREQ_MHZ - 1));

   // 1 us prescaler, wraps to 0 on the tick cycle.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         presc <= {PW{1'b0}};
      end else if (tick) begin
         presc <= {PW{1'b0}};
      end else begin
         presc <= presc + 1'b1;
      end
   end

   for (genvar i = 0; i < N_IGBT; i++) begin : g_igbt
      fb_debounce #(.DEB_US(DEB_US), .INVERT(1'b0)) u_fb (
         .clk(sys_clk), .rst(sys_rst), .tick(tick),
         .din(IGBT_fb[i]), .dout(IGBT_fb_db[i])
      );
      fb_debounce #(.DEB_US(DEB_US), .INVERT(1'b1)) u_desat (
         .clk(sys_clk), .rst(sys_rst), .tick(tick),
         .din(IGBT_desat_n[i]), .dout(desat_db[i])
      );
   end

   for (genvar j = 0; j < N_SCR; j++) begin : g_scr
      fb_debounce #(.DEB_US(DEB_US), .INVERT(1'b0)) u_fb (
         .clk(sys_clk), .rst(sys_rst), .tick(tick),
         .din(SCR_fb[j]), .dout(SCR_fb_db[j])
      );
   end

   assign cmd_all = {SCR_cmd, IGBT_cmd};
   assign fb_all  = {SCR_fb_db, IGBT_fb_db};
   assign eq      = ~(cmd_all ^ fb_all);

   // Mismatch FSM state and timer registers.
   always_ff @(posedge sys_clk) begin
      for (int c = 0; c < NCH; c++) begin
         if (sys_rst) begin
            state[c] <= ST_IDLE;
            timer[c] <= {TW{1'b0}};
         end else begin
            state[c] <= state_nxt[c];
            timer[c] <= timer_nxt[c];
         end
      end
   end

   // Mismatch FSM next state; in WAIT the fault takes precedence over fault_clr.
   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         state_nxt[c] = state[c];
         timer_nxt[c] = timer[c];
         case (state[c])
            ST_IDLE: begin
               timer_nxt[c] = {TW{1'b0}};
               if (!eq[c]) begin
                  state_nxt[c] = ST_WAIT;
               end else begin
                  state_nxt[c] = ST_IDLE;
               end
            end
            ST_WAIT: begin
               if (eq[c]) begin
                  state_nxt[c] = ST_IDLE;
               end else if (timer[c] == TW'(MISMATCH_US)) begin
                  state_nxt[c] = ST_FAULT;
               end else if (tick && (timer[c] < TW'(MISMATCH_US))) begin
                  timer_nxt[c] = timer[c] + 1'b1;
               end else begin
                  timer_nxt[c] = timer[c];
               end
            end
            ST_FAULT: begin
               if (fault_clr && eq[c]) begin
                  state_nxt[c] = ST_IDLE;
               end else begin
                  state_nxt[c] = ST_FAULT;
               end
            end
            default: begin
               state_nxt[c] = ST_IDLE;
               timer_nxt[c] = {TW{1'b0}};
            end
         endcase
      end
   end

   // Fault bit decoded from the registered FSM state.
   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         fault_vec[c] = (state[c] == ST_FAULT);
      end
   end

   assign IGBT_fault = fault_vec[N_IGBT-1:0];
   assign SCR_fault  = fault_vec[NCH-1:N_IGBT];

   // DESAT latch: set while commanded on; clearing needs the DESAT to be gone.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         desat_flag <= {N_IGBT{1'b0}};
      end else begin
         desat_flag <= (desat_db & IGBT_cmd) |
                       (desat_flag & ~({N_IGBT{fault_clr}} & ~desat_db));
      end
   end

   assign fault_any = (|fault_vec) | (|desat_flag);

   // Trip request is fault_any delayed one clock.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         trip_req <= 1'b0;
      end else begin
         trip_req <= fault_any;
      end
   end

`ifdef GATE_FB_FAULT_CNT_EN
   // Rising edge of fault_any is detected against its registered copy trip_req.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         fault_cnt <= 8'd0;
      end else if (fault_any && !trip_req && (fault_cnt != 8'hFF)) begin
         fault_cnt <= fault_cnt + 8'd1;
      end
   end
`endif

endmodule
